// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer control path.
// Contents: opcode constants, T-state constants, control-word bit positions
// and a helper that builds a one-hot control-word mask.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STEP_W   = 3;
  localparam int unsigned CW_W     = 16;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [STEP_W-1:0]   step_t;
  typedef logic [CW_W-1:0]     cw_t;

  localparam opcode_t OP_LDA = 4'h0;
  localparam opcode_t OP_ADD = 4'h1;
  localparam opcode_t OP_SUB = 4'h2;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_JZ  = 4'h8;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  localparam step_t T0       = 3'd0;
  localparam step_t T1       = 3'd1;
  localparam step_t T2       = 3'd2;
  localparam step_t T3       = 3'd3;
  localparam step_t T4       = 3'd4;
  localparam step_t MAX_STEP = T4;

  // Control-word bit positions
  localparam int unsigned CW_PC_OE     = 0;
  localparam int unsigned CW_PC_INC    = 1;
  localparam int unsigned CW_PC_WE     = 2;
  localparam int unsigned CW_MAR_WE    = 3;
  localparam int unsigned CW_RAM_OE    = 4;
  localparam int unsigned CW_RAM_WE    = 5;
  localparam int unsigned CW_IR_WE     = 6;
  localparam int unsigned CW_IR_OA     = 7;
  localparam int unsigned CW_IR_ARG_OE = 8;
  localparam int unsigned CW_A_WE      = 9;
  localparam int unsigned CW_A_OE      = 10;
  localparam int unsigned CW_B_WE      = 11;
  localparam int unsigned CW_ALU_OE    = 12;
  localparam int unsigned CW_ALU_SUB   = 13;
  localparam int unsigned CW_FLG_WE    = 14;
  localparam int unsigned CW_OUT_WE    = 15;

  function automatic cw_t cw_bit(input int unsigned pos);
    return cw_t'(1) << pos;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode decode for the control sequencer.
// Ports:
//   i_step, i_opcode, i_cf, i_zf, i_halted : current T-state, opcode, flags, HALT bit
//   o_cw        : control word (bit positions from cpu_pkg)
//   o_last_step : the current step is the final one of the instruction
module ctrl_decode
  import cpu_pkg::*;
(
  input  step_t   i_step,
  input  opcode_t i_opcode,
  input  logic    i_cf,
  input  logic    i_zf,
  input  logic    i_halted,
  output cw_t     o_cw,
  output logic    o_last_step
);

  always_comb begin
    o_cw        = '0;
    o_last_step = 1'b0;
    if (!i_halted) begin
      case (i_step)
        T0: o_cw = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_WE);
        T1: o_cw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_WE) | cw_bit(CW_PC_INC);
        T2: begin
          o_cw[CW_IR_OA] = 1'b1;
          o_last_step    = 1'b1;
          case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              o_cw[CW_IR_ARG_OE] = 1'b1;
              o_cw[CW_MAR_WE]    = 1'b1;
              o_last_step        = 1'b0;
            end
            OP_LDI: begin
              o_cw[CW_IR_ARG_OE] = 1'b1;
              o_cw[CW_A_WE]      = 1'b1;
            end
            OP_JMP: begin
              o_cw[CW_IR_ARG_OE] = 1'b1;
              o_cw[CW_PC_WE]     = 1'b1;
            end
            OP_JC: begin
              o_cw[CW_IR_ARG_OE] = 1'b1;
              o_cw[CW_PC_WE]     = i_cf;
            end
            OP_JZ: begin
              o_cw[CW_IR_ARG_OE] = 1'b1;
              o_cw[CW_PC_WE]     = i_zf;
            end
            OP_OUT: begin
              o_cw[CW_A_OE]   = 1'b1;
              o_cw[CW_OUT_WE] = 1'b1;
            end
            default: ; // HLT and NOPs: no strobes
          endcase
        end
        T3: begin
          o_cw[CW_IR_OA] = 1'b1;
          o_last_step    = 1'b1;
          case (i_opcode)
            OP_LDA: begin
              o_cw[CW_RAM_OE] = 1'b1;
              o_cw[CW_A_WE]   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_cw[CW_RAM_OE] = 1'b1;
              o_cw[CW_B_WE]   = 1'b1;
              o_last_step     = 1'b0;
            end
            OP_STA: begin
              o_cw[CW_A_OE]   = 1'b1;
              o_cw[CW_RAM_WE] = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          o_cw[CW_IR_OA] = 1'b1;
          o_last_step    = 1'b1;
          if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
            o_cw[CW_ALU_OE]  = 1'b1;
            o_cw[CW_A_WE]    = 1'b1;
            o_cw[CW_FLG_WE]  = 1'b1;
            o_cw[CW_ALU_SUB] = (i_opcode == OP_SUB);
          end
        end
        // Unreachable step values: no strobes, fall back to T0
        default: o_last_step = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Microcoded control sequencer: holds the T-state counter and HALT bit, and
// exposes the decoded control strobes for the datapath.
// Ports:
//   clk, clr        : clock, asynchronous active-high reset
//   opcode, cf, zf  : IR opcode nibble, latched carry / zero flags
//   step, halted    : current T-state and HALT indication
//   remaining       : one output per bus-control strobe
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] opcode,
  input  logic           cf,
  input  logic           zf,
  output logic [2:0]     step,
  output logic           halted,
  output logic           pc_oe,
  output logic           pc_inc,
  output logic           pc_we,
  output logic           mar_we,
  output logic           ram_oe,
  output logic           ram_we,
  output logic           ir_we,
  output logic           ir_oa,
  output logic           ir_arg_oe,
  output logic           a_we,
  output logic           a_oe,
  output logic           b_we,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           flg_we,
  output logic           out_we
);

  step_t r_step;
  logic  r_halted;
  step_t w_step_nxt;
  logic  w_halted_nxt;
  cw_t   w_cw;
  logic  w_last_step;

  ctrl_decode u_decode (
    .i_step      (r_step),
    .i_opcode    (opcode),
    .i_cf        (cf),
    .i_zf        (zf),
    .i_halted    (r_halted),
    .o_cw        (w_cw),
    .o_last_step (w_last_step)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_step_nxt   = r_step;
    w_halted_nxt = r_halted;
    if (!r_halted) begin
      if (w_last_step) begin
        w_step_nxt = T0;
        // HLT retires in T2; step parks at 0 while halted
        if (r_step == T2 && opcode == OP_HLT) begin
          w_halted_nxt = 1'b1;
        end
      end else begin
        w_step_nxt = r_step + 3'd1;
      end
    end
  end

  always_comb begin
    step      = r_step;
    halted    = r_halted;
    pc_oe     = w_cw[CW_PC_OE];
    pc_inc    = w_cw[CW_PC_INC];
    pc_we     = w_cw[CW_PC_WE];
    mar_we    = w_cw[CW_MAR_WE];
    ram_oe    = w_cw[CW_RAM_OE];
    ram_we    = w_cw[CW_RAM_WE];
    ir_we     = w_cw[CW_IR_WE];
    ir_oa     = w_cw[CW_IR_OA];
    ir_arg_oe = w_cw[CW_IR_ARG_OE];
    a_we      = w_cw[CW_A_WE];
    a_oe      = w_cw[CW_A_OE];
    b_we      = w_cw[CW_B_WE];
    alu_oe    = w_cw[CW_ALU_OE];
    alu_sub   = w_cw[CW_ALU_SUB];
    flg_we    = w_cw[CW_FLG_WE];
    out_we    = w_cw[CW_OUT_WE];
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Microcoded control sequencer for the 8-bit computer. It steps through a 5-step T-state machine, fetches instructions into the instruction register, decodes the 4-bit opcode the register presents, and drives every bus-control strobe (PC, MAR, RAM, IR, A, B, ALU, flags, output register) for each step. It sits between the instruction register and the rest of the datapath and is the only source of control enables in the design.

## Interface
- OPW, 4, opcode width; fixed at 4 for this ISA.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous active-high reset.
- opcode  in  OPW  instruction register upper nibble; sampled from T2 onward.
- cf  in  1  latched carry flag.
- zf  in  1  latched zero flag.
- step  out  3  current T-state, 0..4.
- halted  out  1  high while in HALT.
- pc_oe, pc_inc, pc_we  out  1 each  program counter: drive bus, increment, load from bus.
- mar_we  out  1  memory address register load.
- ram_oe, ram_we  out  1 each  RAM read-to-bus, write-from-bus.
- ir_we, ir_oa, ir_arg_oe  out  1 each  IR load, opcode-output enable, low-nibble operand to bus.
- a_we, a_oe, b_we  out  1 each  A load, A drive bus, B load.
- alu_oe, alu_sub, flg_we  out  1 each  ALU result to bus, subtract select, flag register load.
- out_we  out  1  output register load.

## Operation
- States: RUN (step 0..4) and HALT. Outputs are combinational decode of the registered step, `halted`, the opcode, cf and zf. They must not depend on opcode during T0 and T1.
- ir_oa is high in T2–T4 of RUN and low otherwise.
- Fetch, all opcodes:
  - T0: pc_oe, mar_we.
  - T1: ram_oe, ir_we, pc_inc.
- Execute (opcode hex):
  - LDA 0:
    - T2: ir_arg_oe, mar_we.
    - T3: ram_oe, a_we. Ends.
  - ADD 1:
    - T2: ir_arg_oe, mar_we.
    - T3: ram_oe, b_we.
    - T4: alu_oe, a_we, flg_we. Ends.
  - SUB 2: as ADD, with alu_sub also high in T4.
  - STA 4:
    - T2: ir_arg_oe, mar_we.
    - T3: a_oe, ram_we. Ends.
  - LDI 5: T2: ir_arg_oe, a_we. Ends.
  - JMP 6: T2: ir_arg_oe, pc_we. Ends.
  - JC 7: T2: ir_arg_oe and pc_we only if cf=1. Ends in T2 either way.
  - JZ 8: as JC, conditioned on zf.
  - OUT E: T2: a_oe, out_we. Ends.
  - HLT F: T2: no strobes. Next edge enters HALT.
  - All other opcodes (3, 9–D): NOP, end at T2.
- "Ends" means the step after the final step is T0. There are no idle trailing steps.
- HALT: all strobes 0, halted=1, step=0. HALT is exited only by clr.
- At most one bus driver (pc_oe, ram_oe, ir_arg_oe, a_oe, alu_oe) is high in any step. This is an invariant.

## Timing
- Async reset: step=0, RUN, halted=0. All strobes are at their T0 values (pc_oe=1, mar_we=1) immediately after reset, with no clock required.
- Every step lasts exactly one clock. Instruction lengths:
  - ADD/SUB: 5 cycles.
  - LDA/STA: 4 cycles.
  - LDI/JMP/JC/JZ/OUT/NOP: 3 cycles.
  - HLT: 3 cycles, then HALT.
- cf/zf are sampled combinationally during T2. A flag write in an earlier instruction's T4 is visible in the next instruction's T2.
- clr asserted mid-instruction returns the block to T0 asynchronously. The partial instruction is abandoned and no further strobes are issued for it.
- clr released coincident with a clk edge: that edge does not advance the step. The first advance is on the following edge.
- Step counter values 5–7 are unreachable. If reached, they decode to no strobes and return to T0 on the next edge.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (OP_LDA … OP_HLT).
  - Step constants T0–T4 and MAX_STEP.
  - Control-word bit positions, so the IR, ALU and bench use the same encoding.
- One natural sub-module, `ctrl_decode`. It is a purely combinational map from (step, opcode, cf, zf, halted) to control word plus a `last_step` flag. The parent ctrl_seq holds only the step register and the HALT bit.

## Test plan
- Reset: pulse clr with no clock → step=0, halted=0, pc_oe=1, mar_we=1, all other strobes 0.
- LDA (opcode 0) → T0 {pc_oe, mar_we}, T1 {ram_oe, ir_we, pc_inc}, T2 {ir_arg_oe, mar_we}, T3 {ram_oe, a_we}; step returns to 0 on the 5th edge.
- SUB (opcode 2) → T4 shows alu_oe=1, a_we=1, flg_we=1, alu_sub=1; total 5 cycles.
- JC (opcode 7):
  - cf=0 → T2 has ir_arg_oe=1, pc_we=0.
  - cf=1 → pc_we=1.
  - Both cases back at T0 after 3 cycles.
  - Repeat with JZ/zf.
- HLT (opcode F) → halted=1 from the 4th edge, all strobes 0 for 20 further cycles; clr → restart at T0.
- clr asserted during T3 of ADD → step=0 immediately, no b_we seen afterward. Run 200 random opcodes and check the single-bus-driver invariant on every cycle.
